prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It receives a byte stream over a valid/ready interface and packs the bytes into 16-bit instruction words. It writes those words into instruction memory through a write port and holds the CPU in reset until a complete image with a correct checksum has been loaded. It is the only writer of instruction memory.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/prog_loader.sv | 103 ++++++++++
 tb/tb_prog_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader state encoding and datapath widths.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } load_state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: packs a checksummed byte stream into 16-bit words,
// writes them to instruction memory, and holds the CPU in reset until the image is good.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// COUNT | expecting the word-count byte
// HI    | expecting the high byte of a word
// LO    | expecting the low byte; accepting it issues the memory write
// CSUM  | expecting the checksum byte
// DONE  | image good, CPU released
// ERR   | checksum mismatch, CPU held in reset
module prog_loader
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSTR_W-1:0]  mem_wdata,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);

  load_state_t       state;
  logic [BYTE_W-1:0] remaining;
  logic [BYTE_W-1:0] hi_byte;
  logic [BYTE_W-1:0] sum;
  logic [ADDR_W-1:0] index;
  logic              accept;

  // Status outputs are pure decodes of the state register, so they stay glitch-free
  // and change exactly one cycle after the accepting edge.
  assign in_ready  = (state == ST_COUNT) || (state == ST_HI) ||
                     (state == ST_LO)    || (state == ST_CSUM);
  assign busy      = in_ready;
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERR);
  assign cpu_reset = (state != ST_DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      hi_byte   <= '0;
      sum       <= '0;
      index     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state <= ST_COUNT;
            index <= '0;
          end
        end
        ST_COUNT: begin
          if (accept) begin
            remaining <= in_data;
            sum       <= in_data;
            state     <= (in_data != '0) ? ST_HI : ST_CSUM;
          end
        end
        ST_HI: begin
          if (accept) begin
            hi_byte <= in_data;
            sum     <= sum + in_data;
            state   <= ST_LO;
          end
        end
        ST_LO: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + index;
            mem_wdata <= {hi_byte, in_data};
            index     <= index + 1'b1;
            remaining <= remaining - 1'b1;
            sum       <= sum + in_data;
            // remaining still holds the pre-decrement count here
            state     <= (remaining != 8'd1) ? ST_HI : ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (accept) state <= (sum == in_data) ? ST_DONE : ST_ERR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good, bad, stalled, empty and interrupted image loads.
module tb_prog_loader;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [0:15];
  logic [15:0] wr_addr [0:15];
  logic [15:0] wr_data [0:15];
  int          wr_cnt = 0;

  prog_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we && wr_cnt < 16) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_wdata;
    end
    if (mem_we) wr_cnt = wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Presents img[0..n-1]; a byte advances only when it is offered while in_ready is high.
  task automatic send_image(input int n, input bit stall);
    int  i = 0;
    int  cyc = 0;
    bit  phase = 1'b0;
    while (i < n && cyc < 200) begin
      @(negedge clk);
      in_valid = stall ? phase : 1'b1;
      phase    = !phase;
      in_data  = img[i];
      if (in_valid && in_ready) i++;
      cyc++;
    end
    if (cyc >= 200) check("send_timeout", cyc, 0);
  endtask

  task automatic finish_image();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_good(input logic [7:0] csum);
    img[0] = 8'h02; img[1] = 8'h12; img[2] = 8'h34;
    img[3] = 8'hAB; img[4] = 8'hCD; img[5] = csum;
  endtask

  task automatic check_two_writes(input string tag);
    #1;
    check({tag, "_wr_cnt"}, wr_cnt, 2);
    check({tag, "_addr0"}, wr_addr[0], 16'h0000);
    check({tag, "_data0"}, wr_data[0], 16'h1234);
    check({tag, "_addr1"}, wr_addr[1], 16'h0001);
    check({tag, "_data1"}, wr_data[1], 16'hABCD);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;

    // good image at full rate
    load_good(8'hC0);
    wr_cnt = 0;
    pulse_start();
    #1;
    check("good_busy", busy, 1);
    check("good_ready", in_ready, 1);
    send_image(6, 1'b0);
    finish_image();
    #1;
    check("good_done", done, 1);
    check("good_cpu_reset", cpu_reset, 0);
    check("good_error", error, 0);
    check("good_busy_end", busy, 0);
    check_two_writes("good");

    // bad checksum
    load_good(8'hC1);
    wr_cnt = 0;
    pulse_start();
    #1;
    check("bad_restart_cpu_reset", cpu_reset, 1);
    check("bad_restart_done", done, 0);
    send_image(6, 1'b0);
    finish_image();
    #1;
    check("bad_error", error, 1);
    check("bad_done", done, 0);
    check("bad_cpu_reset", cpu_reset, 1);
    check_two_writes("bad");

    // good image with in_valid low every other cycle
    load_good(8'hC0);
    wr_cnt = 0;
    pulse_start();
    #1;
    check("stall_error_cleared", error, 0);
    send_image(6, 1'b1);
    finish_image();
    #1;
    check("stall_done", done, 1);
    check("stall_cpu_reset", cpu_reset, 0);
    repeat (2) @(negedge clk);
    check_two_writes("stall");

    // empty image
    img[0] = 8'h00; img[1] = 8'h00;
    wr_cnt = 0;
    pulse_start();
    send_image(2, 1'b0);
    finish_image();
    #1;
    check("empty_done", done, 1);
    check("empty_cpu_reset", cpu_reset, 0);
    repeat (2) @(negedge clk);
    check("empty_wr_cnt", wr_cnt, 0);

    // reset after the first word has been written
    load_good(8'hC0);
    wr_cnt = 0;
    pulse_start();
    send_image(3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_in_ready", in_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_mem_we", mem_we, 0);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_done", done, 0);
    check("mid_mem_addr", mem_addr, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("mid_wr_cnt", wr_cnt, 1);
    check("mid_data0", wr_data[0], 16'h1234);

    wr_cnt = 0;
    pulse_start();
    send_image(6, 1'b0);
    finish_image();
    #1;
    check("after_done", done, 1);
    check("after_cpu_reset", cpu_reset, 0);
    check_two_writes("after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
